parc_core_muldiv_wb_buffer: RTL and testbench



---
 rtl/parc_core_muldiv_wb_buffer_pkg.sv | 32 +++
 rtl/parc_core_muldiv_tag_queue.sv | 59 +++++
 rtl/parc_core_muldiv_wb_buffer.sv | 68 ++++++
 tb/tb_parc_core_muldiv_wb_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parc_core_muldiv_wb_buffer_pkg.sv
// Shared types and constants for the mul/div writeback buffer.
// Covers fn encodings, field widths, the tag entry layout and the result half-select.
package parc_core_muldiv_wb_buffer_pkg;

    localparam int MULDIV_FN_W     = 3;
    localparam int RF_ADDR_W       = 5;
    localparam int MULDIV_RESULT_W = 64;
    localparam int WB_DATA_W       = 32;

    localparam logic [MULDIV_FN_W-1:0] MULDIV_FN_MUL  = 3'd0;
    localparam logic [MULDIV_FN_W-1:0] MULDIV_FN_DIV  = 3'd1;
    localparam logic [MULDIV_FN_W-1:0] MULDIV_FN_DIVU = 3'd2;
    localparam logic [MULDIV_FN_W-1:0] MULDIV_FN_REM  = 3'd3;
    localparam logic [MULDIV_FN_W-1:0] MULDIV_FN_REMU = 3'd4;

    typedef struct packed {
        logic [MULDIV_FN_W-1:0] fn;
        logic [RF_ADDR_W-1:0]   waddr;
    } muldiv_tag_t;

    // Remainders live in the upper half. Every other code, including the
    // unused 5-7, takes the lower half.
    function automatic logic [WB_DATA_W-1:0] muldiv_half_sel(
        input logic [MULDIV_FN_W-1:0]     fn,
        input logic [MULDIV_RESULT_W-1:0] result
    );
        if (fn == MULDIV_FN_REM || fn == MULDIV_FN_REMU)
            return result[63:32];
        return result[31:0];
    endfunction

endpackage

// File: rtl/parc_core_muldiv_tag_queue.sv
// In-order FIFO of {fn, waddr} tags for mul/div ops in flight.
// full/empty come from the registered count, so a pop never frees a slot in the same cycle.
module parc_core_muldiv_tag_queue
    import parc_core_muldiv_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enq_val,
    input  muldiv_tag_t            enq_tag,
    input  logic                   deq,
    output muldiv_tag_t            deq_tag,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    muldiv_tag_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq_fire;
    logic          deq_fire;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign enq_fire = enq_val && !full;
    assign deq_fire = deq && !empty;
    assign deq_tag  = mem[rd_ptr];

    // Tag storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[wr_ptr] <= enq_tag;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq_fire)
                rd_ptr <= rd_ptr + AW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/parc_core_muldiv_wb_buffer.sv
// Pairs mul/div results in issue order with their tags, selects the 32-bit half,
// and presents each one to the W stage through a registered val/rdy port.
module parc_core_muldiv_wb_buffer
    import parc_core_muldiv_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       tag_val,
    input  logic [MULDIV_FN_W-1:0]     tag_fn,
    input  logic [RF_ADDR_W-1:0]       tag_waddr,
    output logic                       tag_rdy,
    input  logic [MULDIV_RESULT_W-1:0] muldivresp_msg_result,
    input  logic                       muldivresp_val,
    output logic                       muldivresp_rdy,
    output logic                       wb_val,
    input  logic                       wb_rdy,
    output logic [WB_DATA_W-1:0]       wb_data,
    output logic [RF_ADDR_W-1:0]       wb_waddr,
    output logic [MULDIV_FN_W-1:0]     wb_fn,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    muldiv_tag_t enq_tag;
    muldiv_tag_t head_tag;
    logic        q_full;
    logic        q_empty;
    logic        resp_accept;

    assign enq_tag = '{fn: tag_fn, waddr: tag_waddr};

    parc_core_muldiv_tag_queue #(.DEPTH(DEPTH)) u_tag_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .enq_val (tag_val),
        .enq_tag (enq_tag),
        .deq     (resp_accept),
        .deq_tag (head_tag),
        .full    (q_full),
        .empty   (q_empty),
        .count   (count)
    );

    assign tag_rdy        = !q_full;
    // Accept only when a tag exists and the output slot is free or draining.
    assign muldivresp_rdy = !q_empty && (!wb_val || wb_rdy);
    assign resp_accept    = muldivresp_val && muldivresp_rdy;
    assign busy           = !q_empty || wb_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_val   <= 1'b0;
            wb_data  <= '0;
            wb_waddr <= '0;
            wb_fn    <= '0;
        end else if (resp_accept) begin
            wb_val   <= 1'b1;
            wb_data  <= muldiv_half_sel(head_tag.fn, muldivresp_msg_result);
            wb_waddr <= head_tag.waddr;
            wb_fn    <= head_tag.fn;
        end else if (wb_val && wb_rdy) begin
            wb_val   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parc_core_muldiv_wb_buffer.sv
// Directed bench for parc_core_muldiv_wb_buffer: ordering, half select,
// backpressure, full/empty tag queue, pointer wrap and mid-operation reset.
module tb_parc_core_muldiv_wb_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          tag_val;
    logic [2:0]    tag_fn;
    logic [4:0]    tag_waddr;
    logic          tag_rdy;
    logic [63:0]   muldivresp_msg_result;
    logic          muldivresp_val;
    logic          muldivresp_rdy;
    logic          wb_val;
    logic          wb_rdy;
    logic [31:0]   wb_data;
    logic [4:0]    wb_waddr;
    logic [2:0]    wb_fn;
    logic          busy;
    logic [CW-1:0] count;

    int vec  = 0;
    int errs = 0;

    parc_core_muldiv_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .tag_val               (tag_val),
        .tag_fn                (tag_fn),
        .tag_waddr             (tag_waddr),
        .tag_rdy               (tag_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy),
        .wb_val                (wb_val),
        .wb_rdy                (wb_rdy),
        .wb_data               (wb_data),
        .wb_waddr              (wb_waddr),
        .wb_fn                 (wb_fn),
        .busy                  (busy),
        .count                 (count)
    );

    always #5 clk = ~clk;

    // fn codes 5-7 are never issued by this bench.
    always @(posedge clk)
        if (reset_n && tag_val && tag_rdy)
            assert (tag_fn <= 3'd4) else $error("illegal fn issued");

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] fn, input logic [4:0] waddr);
        tag_val = 1'b1; tag_fn = fn; tag_waddr = waddr;
        step();
        tag_val = 1'b0;
    endtask

    task automatic test_reset();
        vec++; if (count !== '0) begin errs++; $display("FAIL reset_count got %0d exp 0", count); end
        vec++; if (tag_rdy !== 1'b1) begin errs++; $display("FAIL reset_tag_rdy got %b exp 1", tag_rdy); end
        vec++; if (muldivresp_rdy !== 1'b0) begin errs++; $display("FAIL reset_resp_rdy got %b exp 0", muldivresp_rdy); end
        vec++; if (wb_val !== 1'b0) begin errs++; $display("FAIL reset_wb_val got %b exp 0", wb_val); end
        vec++; if ({wb_data, wb_waddr, wb_fn} !== 40'h0) begin errs++; $display("FAIL reset_wb_fields got %h/%h/%h exp 0", wb_data, wb_waddr, wb_fn); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_mul();
        issue(3'd0, 5'd5);
        vec++; if (count !== CW'(1)) begin errs++; $display("FAIL mul_count got %0d exp 1", count); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL mul_busy got %b exp 1", busy); end
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'hffffffff_ffffffc0;
        #1;
        vec++; if (muldivresp_rdy !== 1'b1) begin errs++; $display("FAIL mul_resp_rdy got %b exp 1", muldivresp_rdy); end
        vec++; if (wb_val !== 1'b0) begin errs++; $display("FAIL mul_wb_early got %b exp 0", wb_val); end
        step();
        muldivresp_val = 1'b0;
        vec++; if (wb_val !== 1'b1) begin errs++; $display("FAIL mul_wb_val got %b exp 1", wb_val); end
        vec++; if (wb_data !== 32'hffffffc0) begin errs++; $display("FAIL mul_data got %h exp ffffffc0", wb_data); end
        vec++; if (wb_waddr !== 5'd5) begin errs++; $display("FAIL mul_waddr got %0d exp 5", wb_waddr); end
        vec++; if (wb_fn !== 3'd0) begin errs++; $display("FAIL mul_fn got %0d exp 0", wb_fn); end
        step();
        vec++; if (wb_val !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL mul_drain got val=%b busy=%b exp 0/0", wb_val, busy); end
    endtask

    task automatic test_back_to_back();
        issue(3'd3, 5'd7);
        issue(3'd2, 5'd8);
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'h0000002e_0000000a;
        step();
        vec++; if (wb_data !== 32'h2e || wb_waddr !== 5'd7 || wb_fn !== 3'd3) begin errs++; $display("FAIL b2b_rem got %h/%0d/%0d exp 2e/7/3", wb_data, wb_waddr, wb_fn); end
        vec++; if (muldivresp_rdy !== 1'b1) begin errs++; $display("FAIL b2b_resp_rdy got %b exp 1", muldivresp_rdy); end
        step();
        muldivresp_val = 1'b0;
        vec++; if (wb_val !== 1'b1 || wb_data !== 32'h0a || wb_waddr !== 5'd8 || wb_fn !== 3'd2) begin errs++; $display("FAIL b2b_divu got %b/%h/%0d/%0d exp 1/0a/8/2", wb_val, wb_data, wb_waddr, wb_fn); end
        step();
        vec++; if (wb_val !== 1'b0 || count !== '0) begin errs++; $display("FAIL b2b_drain got val=%b count=%0d exp 0/0", wb_val, count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) issue(3'd0, 5'(10 + i));
        vec++; if (count !== CW'(DEPTH)) begin errs++; $display("FAIL full_count got %0d exp %0d", count, DEPTH); end
        vec++; if (tag_rdy !== 1'b0) begin errs++; $display("FAIL full_tag_rdy got %b exp 0", tag_rdy); end
        issue(3'd0, 5'd31);
        vec++; if (count !== CW'(DEPTH)) begin errs++; $display("FAIL full_blocked got %0d exp %0d", count, DEPTH); end
        // Pop while a blocked enqueue is pending: the slot must not be reused this edge.
        tag_val = 1'b1; tag_fn = 3'd0; tag_waddr = 5'd31;
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'h0000_0000_0000_0100;
        step();
        tag_val = 1'b0;
        vec++; if (count !== CW'(DEPTH - 1)) begin errs++; $display("FAIL full_pop_count got %0d exp %0d", count, DEPTH - 1); end
        vec++; if (tag_rdy !== 1'b1) begin errs++; $display("FAIL full_tag_rdy_back got %b exp 1", tag_rdy); end
        vec++; if (wb_data !== 32'h100 || wb_waddr !== 5'd10) begin errs++; $display("FAIL full_first got %h/%0d exp 100/10", wb_data, wb_waddr); end
        for (int i = 1; i < DEPTH; i++) begin
            muldivresp_msg_result = 64'h0000_0000_0000_0100 + 64'(i);
            step();
            vec++; if (wb_data !== 32'h100 + 32'(i) || wb_waddr !== 5'(10 + i)) begin errs++; $display("FAIL full_drain%0d got %h/%0d exp %h/%0d", i, wb_data, wb_waddr, 32'h100 + 32'(i), 10 + i); end
        end
        muldivresp_val = 1'b0;
        step();
        vec++; if (wb_val !== 1'b0 || count !== '0) begin errs++; $display("FAIL full_end got val=%b count=%0d exp 0/0", wb_val, count); end
    endtask

    task automatic test_empty_resp();
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'hdead_beef_cafe_f00d;
        for (int i = 0; i < 2; i++) begin
            #1;
            vec++; if (muldivresp_rdy !== 1'b0) begin errs++; $display("FAIL empty_resp_rdy got %b exp 0", muldivresp_rdy); end
            step();
            vec++; if (wb_val !== 1'b0) begin errs++; $display("FAIL empty_no_wb got %b exp 0", wb_val); end
        end
        muldivresp_val = 1'b0;
    endtask

    task automatic test_backpressure();
        wb_rdy = 1'b0;
        issue(3'd4, 5'd20);
        issue(3'd1, 5'd21);
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'h00000011_00000022;
        step();
        vec++; if (wb_val !== 1'b1 || wb_data !== 32'h11 || wb_waddr !== 5'd20 || wb_fn !== 3'd4) begin errs++; $display("FAIL bp_first got %b/%h/%0d/%0d exp 1/11/20/4", wb_val, wb_data, wb_waddr, wb_fn); end
        muldivresp_msg_result = 64'h00000033_00000044;
        for (int i = 0; i < 5; i++) begin
            #1;
            vec++; if (muldivresp_rdy !== 1'b0) begin errs++; $display("FAIL bp_resp_rdy%0d got %b exp 0", i, muldivresp_rdy); end
            vec++; if (wb_val !== 1'b1 || wb_data !== 32'h11 || wb_waddr !== 5'd20) begin errs++; $display("FAIL bp_hold%0d got %b/%h/%0d exp 1/11/20", i, wb_val, wb_data, wb_waddr); end
            step();
        end
        vec++; if (count !== CW'(1)) begin errs++; $display("FAIL bp_count got %0d exp 1", count); end
        wb_rdy = 1'b1;
        #1;
        vec++; if (muldivresp_rdy !== 1'b1) begin errs++; $display("FAIL bp_release_rdy got %b exp 1", muldivresp_rdy); end
        step();
        muldivresp_val = 1'b0;
        vec++; if (wb_val !== 1'b1 || wb_data !== 32'h44 || wb_waddr !== 5'd21 || wb_fn !== 3'd1) begin errs++; $display("FAIL bp_second got %b/%h/%0d/%0d exp 1/44/21/1", wb_val, wb_data, wb_waddr, wb_fn); end
        step();
        vec++; if (wb_val !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL bp_drain got val=%b busy=%b exp 0/0", wb_val, busy); end
    endtask

    // Mixed fn set with overlapped issue/response and random idle gaps; wraps the pointers 3 times.
    task automatic test_wrap();
        int n = 3 * DEPTH;
        logic [31:0] hi, lo, exp_d;
        issue(3'd0, 5'd1);
        for (int i = 0; i < n; i++) begin
            tag_val = (i + 1 < n); tag_fn = 3'((i + 1) % 5); tag_waddr = 5'(i + 2);
            hi = 32'ha000_0000 + 32'(i); lo = 32'h0000_b000 + 32'(i);
            exp_d = ((i % 5) >= 3) ? hi : lo;
            muldivresp_val = 1'b1; muldivresp_msg_result = {hi, lo};
            #1;
            vec++; if (muldivresp_rdy !== 1'b1) begin errs++; $display("FAIL wrap_rdy%0d got %b exp 1", i, muldivresp_rdy); end
            step();
            tag_val = 1'b0; muldivresp_val = 1'b0;
            vec++; if (wb_data !== exp_d || wb_waddr !== 5'(i + 1) || wb_fn !== 3'(i % 5)) begin errs++; $display("FAIL wrap_wb%0d got %h/%0d/%0d exp %h/%0d/%0d", i, wb_data, wb_waddr, wb_fn, exp_d, i + 1, i % 5); end
            vec++; if (count !== CW'((i + 1 < n) ? 1 : 0)) begin errs++; $display("FAIL wrap_count%0d got %0d exp %0d", i, count, (i + 1 < n) ? 1 : 0); end
            repeat ($urandom_range(0, 2)) step();
        end
        step();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL wrap_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        wb_rdy = 1'b0;
        for (int i = 0; i < 4; i++) issue(3'd0, 5'(i + 1));
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'h0000_0000_0000_0055;
        step();
        muldivresp_val = 1'b0;
        vec++; if (wb_val !== 1'b1 || count !== CW'(3)) begin errs++; $display("FAIL rmid_pre got val=%b count=%0d exp 1/3", wb_val, count); end
        #2 reset_n = 1'b0;
        #1;
        vec++; if (wb_val !== 1'b0 || {wb_data, wb_waddr, wb_fn} !== 40'h0) begin errs++; $display("FAIL rmid_wb got %b/%h/%0d/%0d exp 0", wb_val, wb_data, wb_waddr, wb_fn); end
        vec++; if (count !== '0 || tag_rdy !== 1'b1 || muldivresp_rdy !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rmid_ctl got cnt=%0d trdy=%b rrdy=%b busy=%b exp 0/1/0/0", count, tag_rdy, muldivresp_rdy, busy); end
        step();
        reset_n = 1'b1; wb_rdy = 1'b1;
        step();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy_after got %b exp 0", busy); end
        issue(3'd0, 5'd9);
        vec++; if (count !== CW'(1)) begin errs++; $display("FAIL rmid_enq got %0d exp 1", count); end
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'h0000_0000_0000_0077;
        step();
        muldivresp_val = 1'b0;
        vec++; if (wb_data !== 32'h77 || wb_waddr !== 5'd9) begin errs++; $display("FAIL rmid_wb_after got %h/%0d exp 77/9", wb_data, wb_waddr); end
        step();
    endtask

    initial begin
        reset_n = 1'b0; tag_val = 1'b0; tag_fn = '0; tag_waddr = '0;
        muldivresp_val = 1'b0; muldivresp_msg_result = '0; wb_rdy = 1'b1;
        step(); step();
        test_reset();
        reset_n = 1'b1;
        test_mul();
        test_back_to_back();
        test_full();
        test_empty_resp();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
